// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long-press/auto-repeat events.
// Every output is registered; the input level is also kept as btn_q for press edge detection.
module button_event #(
  parameter int unsigned LONG_TICKS   = 200,
  parameter int unsigned REPEAT_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] repeat_cnt
);

  localparam logic [15:0] LONG_T   = 16'(LONG_TICKS);
  localparam logic [15:0] REPEAT_T = 16'(REPEAT_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_btn_q;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_press;
  logic        r_release;
  logic        r_long;
  logic        r_repeat;
  logic        r_held;
  logic [7:0]  r_rcnt;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_long_nxt;
  logic        w_repeat_nxt;
  logic        w_held_nxt;
  logic [7:0]  w_rcnt_nxt;

  // Next-state and next-output logic; a sampled release always wins over long/repeat.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    w_held_nxt    = r_held;
    w_rcnt_nxt    = r_rcnt;
    case (r_state)
      ST_IDLE: begin
        if (btn_level && !r_btn_q) begin
          w_press_nxt = 1'b1;
          w_held_nxt  = 1'b1;
          w_cnt_nxt   = 16'd1;
          w_rcnt_nxt  = 8'd0;
          w_state_nxt = ST_PRESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (!btn_level) begin
          w_release_nxt = 1'b1;
          w_held_nxt    = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (r_cnt == LONG_T) begin
          w_long_nxt  = 1'b1;
          w_cnt_nxt   = 16'd1;
          w_state_nxt = ST_LONG;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_LONG: begin
        if (!btn_level) begin
          w_release_nxt = 1'b1;
          w_held_nxt    = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (r_cnt == REPEAT_T) begin
          w_repeat_nxt = 1'b1;
          w_cnt_nxt    = 16'd1;
          if (r_rcnt != 8'hFF) begin
            w_rcnt_nxt = r_rcnt + 8'd1;
          end else begin
            w_rcnt_nxt = r_rcnt;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter, input sample and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_btn_q   <= 1'b0;
      r_cnt     <= 16'd0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
      r_rcnt    <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_btn_q   <= btn_level;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
      r_held    <= w_held_nxt;
      r_rcnt    <= w_rcnt_nxt;
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;
  assign held          = r_held;
  assign repeat_cnt    = r_rcnt;

endmodule
